smol_boi: RTL and testbench
===========================

# smol_boi

SPI slave register file: a serial master writes or reads bytes in a 128 × 8-bit memory over a four-wire mode-0 SPI link. All SPI inputs are asynchronous to the system clock. They are synchronized and edge-detected in the `CLK` domain, so the block sits behind board-level SPI pins as a simple peripheral. Each transaction is one command byte (R/W bit + 7-bit address) followed by one data byte.

## Interface
- `ADDR_W`, default 7: address width; memory depth is 2^ADDR_W.
- `DATA_W`, default 8: word width; the serial data phase is DATA_W bits.
- `SYNC_STAGES`, default 2: flip-flop stages in each input synchronizer.

Ports:
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `SCLK`  in  1  SPI serial clock from the master; asynchronous to `CLK`.
- `CS`  in  1  chip select, active-low.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first.

## Operation
- `SCLK`, `CS` and `MOSI` each pass through a `SYNC_STAGES` synchronizer. A rising-edge pulse is derived from synchronized `SCLK`.
- FSM states are `ADDR`, `WRITE`, `READ`.
- While synchronized `CS` is high, the FSM is forced to `ADDR`, the bit counter is cleared, and `MISO` is 0.
- **`ADDR` state**
  - Each rising-edge pulse shifts synchronized `MOSI` into an 8-bit command register.
  - The first bit is R/W: 1 = read, 0 = write. The next 7 bits are the address, MSB first.
  - After the 8th bit, the address is latched.
  - On a write, go to `WRITE`.
  - On a read, load the shift register with mem[addr] and go to `READ`.
- **`WRITE` state**
  - Shift in 8 bits.
  - On the 8th bit, write mem[addr] and return to `ADDR`.
- **`READ` state**
  - `MISO` = shift register MSB.
  - Each rising-edge pulse shifts left by one.
  - On the 8th pulse, return to `ADDR`; `MISO` returns to 0.
- Back-to-back transactions without `CS` deassertion are legal.
- `CS` rising mid-transaction aborts it. A partial write never modifies memory.

Reset values:
- FSM = `ADDR`, counters 0, `MISO` = 0, all memory words 0.
- Reset asserted mid-transaction aborts immediately.

## Timing
- Input-to-action latency: `SYNC_STAGES` + 1 `CLK` cycles after the `SCLK` rising edge.
- `SCLK` high and low phases must each be ≥ 4 `CLK` periods. `MOSI` must be stable across the rising edge.
- `MISO` is updated within `SYNC_STAGES` + 2 `CLK` cycles after each `SCLK` rising edge, so it is valid at the following falling edge (mode 0).
  - The first read bit is valid before the `SCLK` falling edge that follows the 8th command bit.
- Memory write completes `SYNC_STAGES` + 2 `CLK` cycles after the 8th data-bit rising edge.
- A read of an address in the command immediately after its write returns the new data.

## Configuration
- `SMOL_BOI_MISO_TRISTATE_EN` defined: `MISO` is `1'bz` whenever the FSM is not in `READ` or `CS` is high. Lets several slaves share the line.
- Not defined: `MISO` is driven 0 in those cases.

## Structure
- Package `smol_boi_pkg` holds:
  - the FSM state enum (`ADDR`, `WRITE`, `READ`);
  - default widths (`ADDR_W` = 7, `DATA_W` = 8);
  - the R/W encoding constants (`RW_READ` = 1, `RW_WRITE` = 0).
- Sub-module `smol_boi_sync`: `SYNC_STAGES`-deep synchronizer plus registered rising/falling edge pulse outputs, instantiated once per SPI input.

## Test plan
- **Write/read 0x33.** `CS` = 0. Send command 0_1010101, then 00110011, then 1_1010101 → `MISO` at the next 8 `SCLK` falling edges = 0,0,1,1,0,0,1,1.
- **Unwritten address after reset.** Read address 0x7F → eight 0 bits on `MISO`.
- **Two addresses in one `CS`.** Write 0xA5 to 0x00 and 0x5A to 0x01, then read both → 10100101 then 01011010.
- **`CS` abort mid-write.** Raise `CS` after 4 data bits, then read the same address → previous value unchanged.
- **Async reset mid-read.** Pulse `RST` during the `READ` phase → `MISO` = 0 immediately. A subsequent read returns 0x00.
- **Tristate macro.** With `SMOL_BOI_MISO_TRISTATE_EN` defined → `MISO` = z while `CS` = 1 and during the command phase. Without it → 0.

Source files
------------

// File: rtl/smol_boi_pkg.sv
// rtl/smol_boi_pkg.sv - shared types and constants for the smol_boi SPI register file
package smol_boi_pkg;

    typedef enum logic [1:0] {
        ADDR  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/smol_boi_sync.sv
// rtl/smol_boi_sync.sv - multi-stage input synchronizer with registered edge pulses
module smol_boi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;
    logic              w_q;

    assign w_q = r_sync[STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | STAGES'(i_d);
            r_prev <= w_q;
            r_rise <= w_q & ~r_prev;
            r_fall <= ~w_q & r_prev;
        end
    end

    assign o_q    = w_q;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/smol_boi.sv
// rtl/smol_boi.sv - SPI mode-0 slave register file; optional MISO tristate via SMOL_BOI_MISO_TRISTATE_EN
module smol_boi
    import smol_boi_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic SCLK,
    input  logic CS,
    input  logic MOSI,
    output logic MISO
);

    localparam int CMD_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_cs_n, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    smol_boi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (SCLK),
        .o_q   (w_sclk_q),
        .o_rise(w_sclk_rise),
        .o_fall(w_sclk_fall)
    );

    // Chip select idles deselected so reset never looks like a selection.
    smol_boi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (CS),
        .o_q   (w_cs_n),
        .o_rise(w_cs_rise),
        .o_fall(w_cs_fall)
    );

    smol_boi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (MOSI),
        .o_q   (w_mosi),
        .o_rise(w_mosi_rise),
        .o_fall(w_mosi_fall)
    );

    assign w_unused = &{1'b0, w_sclk_q, w_sclk_fall, w_cs_rise, w_cs_fall,
                        w_mosi_rise, w_mosi_fall};

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CMD_W-2:0]    r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_last;
    logic                w_cmd_rw;
    logic [ADDR_W-1:0]   w_cmd_addr;
    logic [DATA_W-1:0]   w_shift_in;

    // r_cmd holds the first CMD_W-1 bits; the final address bit is still on w_mosi.
    assign w_cmd_rw   = r_cmd[CMD_W-2];
    assign w_cmd_addr = {r_cmd[CMD_W-3:0], w_mosi};
    assign w_shift_in = {r_shift[DATA_W-2:0], w_mosi};
    assign w_last     = (r_state == ADDR) ? (r_cnt == CNT_W'(CMD_W - 1))
                                          : (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ADDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_cs_n) begin
            w_next = ADDR;
        end else if (w_sclk_rise && w_last) begin
            case (r_state)
                ADDR:    w_next = (w_cmd_rw == RW_WRITE) ? WRITE : READ;
                default: w_next = ADDR;
            endcase
        end
    end

    always_comb begin
`ifdef SMOL_BOI_MISO_TRISTATE_EN
        MISO = 1'bz;
`else
        MISO = 1'b0;
`endif
        if (r_state == READ && !w_cs_n) begin
            MISO = r_shift[DATA_W-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_addr  <= '0;
            r_shift <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_cs_n) begin
            r_cnt <= '0;
        end else if (w_sclk_rise) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            case (r_state)
                ADDR: begin
                    r_cmd <= {r_cmd[CMD_W-3:0], w_mosi};
                    if (w_last) begin
                        r_addr <= w_cmd_addr;
                        if (w_cmd_rw == RW_READ) begin
                            r_shift <= r_mem[w_cmd_addr];
                        end
                    end
                end
                // Memory only changes once all data bits have arrived.
                WRITE: begin
                    r_shift <= w_shift_in;
                    if (w_last) begin
                        r_mem[r_addr] <= w_shift_in;
                    end
                end
                default: begin
                    r_shift <= r_shift << 1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smol_boi.sv
// tb/tb_smol_boi.sv - directed self-checking bench for smol_boi
`timescale 1ns/1ps
module tb_smol_boi;

    logic CLK  = 1'b0;
    logic RST  = 1'b1;
    logic SCLK = 1'b0;
    logic CS   = 1'b1;
    logic MOSI = 1'b0;
    logic MISO;

`ifdef SMOL_BOI_MISO_TRISTATE_EN
    localparam logic IDLE = 1'bz;
`else
    localparam logic IDLE = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] rx;

    smol_boi dut (
        .CLK (CLK),
        .RST (RST),
        .SCLK(SCLK),
        .CS  (CS),
        .MOSI(MOSI),
        .MISO(MISO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // rx bit k is MISO just before the falling edge of the k-th transferred bit.
    task automatic xfer(input logic [15:0] tx, input int n, output logic [15:0] res);
        res = '0;
        for (int i = 0; i < n; i++) begin
            MOSI = tx[15-i];
            #80;
            SCLK = 1'b1;
            #80;
            res[15-i] = MISO;
            SCLK = 1'b0;
        end
    endtask

    task automatic sel();
        CS = 1'b0;
        #80;
    endtask

    task automatic desel();
        #80;
        CS = 1'b1;
        #160;
    endtask

    // Read data appears from the 8th command bit's falling edge through the 7th data bit.
    task automatic check_read(input string tag, input logic [15:0] r, input logic [7:0] exp);
        check({tag, "_data"}, {8'h00, r[8:1]}, {8'h00, exp});
        check({tag, "_idle"}, {8'h00, r[15:9], r[0]}, {8'h00, {8{IDLE}}});
    endtask

    initial begin
        #3;
        #50;
        check("reset_miso", {15'b0, MISO}, {15'b0, IDLE});
        RST = 1'b0;
        #100;

        sel();
        xfer(16'h5533, 16, rx);
        check("write_frame_idle", rx, {16{IDLE}});
        xfer(16'hD500, 16, rx);
        check_read("wr_rd_33", rx, 8'h33);
        desel();

        sel();
        xfer(16'hFF00, 16, rx);
        check_read("unwritten_7f", rx, 8'h00);
        desel();

        sel();
        xfer(16'h00A5, 16, rx);
        xfer(16'h015A, 16, rx);
        xfer(16'h8000, 16, rx);
        check_read("rd_addr00", rx, 8'hA5);
        xfer(16'h8100, 16, rx);
        check_read("rd_addr01", rx, 8'h5A);
        desel();

        sel();
        xfer(16'h103C, 16, rx);
        desel();
        sel();
        xfer(16'h10FF, 12, rx);
        #80;
        CS = 1'b1;
        #160;
        sel();
        xfer(16'h9000, 16, rx);
        check_read("abort_keeps_3c", rx, 8'h3C);
        desel();

        sel();
        xfer(16'hD500, 4, rx);
        #40;
        check("cmd_phase_miso", {15'b0, MISO}, {15'b0, IDLE});
        desel();
        check("cs_high_miso", {15'b0, MISO}, {15'b0, IDLE});

        sel();
        xfer(16'h8000, 10, rx);
        #20;
        check("pre_reset_miso", {15'b0, MISO}, 16'h0001);
        RST = 1'b1;
        #1;
        check("reset_mid_read_miso", {15'b0, MISO}, {15'b0, IDLE});
        #49;
        RST = 1'b0;
        #100;
        desel();

        sel();
        xfer(16'h8000, 16, rx);
        check_read("post_reset_addr00", rx, 8'h00);
        xfer(16'hD500, 16, rx);
        check_read("post_reset_addr55", rx, 8'h00);
        desel();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
